// File: rtl/estimate_array.sv
// NCH-channel binarised-neuron estimator: XNOR-popcount accumulate, max-pool, shift/subtract normalise, sign activation.
// Optional SATURATE_EN: ACC saturates at +MAX and NORM clamps to [MIN, MAX] instead of wrapping.
module estimate_array #(
  parameter int unsigned DW         = 32,
  parameter int unsigned ACCW       = 16,
  parameter int unsigned NCH        = 4,
  parameter int unsigned NORM_SHIFT = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2:0]        com_1,
  input  logic [DW-1:0]     data_1,
  input  logic [NCH*DW-1:0] param,
  output logic [NCH-1:0]    activ,
  output logic              activ_valid
);

  typedef enum logic [2:0] {
    CMD_INI   = 3'd0,
    CMD_ACC   = 3'd1,
    CMD_POOL  = 3'd2,
    CMD_NORM  = 3'd3,
    CMD_ACTIV = 3'd4
  } cmd_e;

  // Operand register must hold either a full XNOR word or a zero-extended ACCW-bit bias.
  localparam int unsigned OPW = (DW > ACCW) ? DW : ACCW;
  localparam logic [ACCW-1:0] MIN = {1'b1, {(ACCW-1){1'b0}}};

  if (ACCW < $clog2(DW) + 2) begin : g_accw_check
    $error("estimate_array: ACCW=%0d too small for DW=%0d", ACCW, DW);
  end

  function automatic logic [ACCW-1:0] popcount2(input logic [DW-1:0] v);
    logic [ACCW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      n = n + ACCW'(v[i]);
    end
    return n << 1;
  endfunction

  logic                       s1_valid;
  cmd_e                       s1_com;
  logic [NCH-1:0][OPW-1:0]    s1_op;
  logic [NCH-1:0][OPW-1:0]    op_d;
  logic [NCH-1:0][ACCW-1:0]   acc_q;
  logic [NCH-1:0][ACCW-1:0]   pool_q;
  logic [NCH-1:0][ACCW-1:0]   acc_next;
  logic [NCH-1:0][ACCW-1:0]   norm_next;

  always_comb begin
    op_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (com_1 == CMD_ACC) begin
        op_d[c] = OPW'(~(data_1 ^ param[c*DW +: DW]));
      end else begin
        op_d[c] = OPW'(param[c*DW +: DW]);
      end
    end
  end

  always_ff @(posedge clk) begin
    s1_com <= cmd_e'(com_1);
    s1_op  <= op_d;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [ACCW-1:0] bias;
    logic [ACCW-1:0] inc;
    assign bias = s1_op[g][ACCW-1:0];
    assign inc  = popcount2(s1_op[g][DW-1:0]);
`ifdef SATURATE_EN
    localparam logic [ACCW-1:0] MAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam int unsigned NW = ACCW + NORM_SHIFT + 1;
    logic [ACCW:0]          sum_ext;
    logic signed [NW-1:0]   norm_full;
    // inc is never negative, so only upward overflow has to be caught.
    assign sum_ext     = {acc_q[g][ACCW-1], acc_q[g]} + {1'b0, inc};
    assign acc_next[g] = ($signed(sum_ext) > $signed({1'b0, MAX})) ? MAX : sum_ext[ACCW-1:0];
    assign norm_full   = (NW'(signed'(pool_q[g])) <<< NORM_SHIFT) - NW'(signed'(bias));
    assign norm_next[g] = (norm_full > NW'(signed'(MAX))) ? MAX :
                          (norm_full < NW'(signed'(MIN))) ? MIN : norm_full[ACCW-1:0];
`else
    assign acc_next[g]  = acc_q[g] + inc;
    assign norm_next[g] = (pool_q[g] << NORM_SHIFT) - bias;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      acc_q       <= '0;
      pool_q      <= {NCH{MIN}};
      activ       <= '0;
      activ_valid <= 1'b0;
    end else begin
      s1_valid    <= in_valid;
      activ_valid <= s1_valid && (s1_com == CMD_ACTIV);
      if (s1_valid) begin
        for (int unsigned c = 0; c < NCH; c++) begin
          case (s1_com)
            CMD_INI: begin
              acc_q[c]  <= s1_op[c][ACCW-1:0];
              pool_q[c] <= MIN;
            end
            CMD_ACC: acc_q[c] <= acc_next[c];
            CMD_POOL: begin
              if ($signed(acc_q[c]) > $signed(pool_q[c])) pool_q[c] <= acc_q[c];
              acc_q[c] <= s1_op[c][ACCW-1:0];
            end
            CMD_NORM:  pool_q[c] <= norm_next[c];
            CMD_ACTIV: activ[c]  <= pool_q[c][ACCW-1];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_estimate_array.sv
// Directed self-checking bench for estimate_array (DW=32, ACCW=16, NCH=4, NORM_SHIFT=6).
module tb_estimate_array;

  localparam logic [2:0] INI = 3'd0, ACC = 3'd1, POOL = 3'd2, NORM = 3'd3, ACTIV = 3'd4, NOP = 3'd7;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [2:0]   com_1;
  logic [31:0]  data_1;
  logic [127:0] param;
  logic [3:0]   activ;
  logic         activ_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  estimate_array #(.DW(32), .ACCW(16), .NCH(4), .NORM_SHIFT(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .com_1(com_1),
    .data_1(data_1), .param(param), .activ(activ), .activ_valid(activ_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  com;
    logic [31:0] data;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [15:0] acc0;
    logic [15:0] acc1;
    logic [15:0] pool0;
    logic [3:0]  act;
    logic        av;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] d, input logic [31:0] w0,
                       input logic [31:0] w1, input logic v);
    in_valid = v;
    com_1    = c;
    data_1   = d;
    param    = {w1, w1, w1, w0};
  endtask

  task automatic idle();
    drive(NOP, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{ACTIV, 32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'h8000, 4'b1111, 1'b1};
    tbl[1]  = '{INI,   32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'h8000, 4'b1111, 1'b0};
    tbl[2]  = '{ACC,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        16'd64,   16'h0,  16'h8000, 4'b1111, 1'b0};
    tbl[3]  = '{POOL,  32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'd64,   4'b1111, 1'b0};
    tbl[4]  = '{POOL,  32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'd64,   4'b1111, 1'b0};
    tbl[5]  = '{ACC,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        16'd64,   16'h0,  16'd64,   4'b1111, 1'b0};
    tbl[6]  = '{POOL,  32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'd64,   4'b1111, 1'b0};
    tbl[7]  = '{NORM,  32'h0,        32'd100,      32'h0,        16'h0,    16'h0,  16'd3996, 4'b1111, 1'b0};
    tbl[8]  = '{ACTIV, 32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'd3996, 4'b0000, 1'b1};
    tbl[9]  = '{INI,   32'h0,        32'd1,        32'h0,        16'd1,    16'h0,  16'h8000, 4'b0000, 1'b0};
    tbl[10] = '{POOL,  32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'd1,    4'b0000, 1'b0};
    tbl[11] = '{NORM,  32'h0,        32'd100,      32'h0,        16'h0,    16'h0,  16'hFFDC, 4'b0000, 1'b0};
    tbl[12] = '{ACTIV, 32'h0,        32'h0,        32'h0,        16'h0,    16'h0,  16'hFFDC, 4'b0001, 1'b1};
    tbl[13] = '{3'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        16'h0,    16'h0,  16'hFFDC, 4'b0001, 1'b0};
    tbl[14] = '{ACC,   32'h000000FF, 32'h0,        32'h000000FF, 16'd48,   16'd64, 16'hFFDC, 4'b0001, 1'b0};
    tbl[15] = '{ACC,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'hF0F0F0F0, 16'd48,   16'd128,16'hFFDC, 4'b0001, 1'b0};

    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    check("rst_acc0", 32'(dut.acc_q[0]), 32'h0);
    check("rst_pool0", 32'(dut.pool_q[0]), 32'h8000);
    check("rst_activ", 32'(activ), 32'h0);
    check("rst_av", 32'(activ_valid), 32'h0);

    // Each vector: accept on one edge, bubble, then look after the state-update edge.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].com, tbl[i].data, tbl[i].w0, tbl[i].w1, 1'b1);
      tick();
      idle();
      tick();
      check($sformatf("v%0d_acc0", i), 32'(dut.acc_q[0]), 32'(tbl[i].acc0));
      check($sformatf("v%0d_acc1", i), 32'(dut.acc_q[1]), 32'(tbl[i].acc1));
      check($sformatf("v%0d_pool0", i), 32'(dut.pool_q[0]), 32'(tbl[i].pool0));
      check($sformatf("v%0d_activ", i), 32'(activ), 32'(tbl[i].act));
      check($sformatf("v%0d_av", i), 32'(activ_valid), 32'(tbl[i].av));
      tick();
      check($sformatf("v%0d_av_drop", i), 32'(activ_valid), 32'h0);
    end

    // Back-to-back INI, ACC, POOL: POOL must see the post-ACC accumulator.
    drive(INI, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    drive(ACC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
    tick();
    drive(POOL, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    idle();
    tick();
    check("b2b_pool0", 32'(dut.pool_q[0]), 32'd64);
    check("b2b_acc0", 32'(dut.acc_q[0]), 32'h0);

    // Unqualified ACC commands must be bubbles.
    drive(ACC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("gate%0d_acc0", i), 32'(dut.acc_q[0]), 32'h0);
      check($sformatf("gate%0d_av", i), 32'(activ_valid), 32'h0);
    end
    idle();
    tick();
    check("gate_tail_acc0", 32'(dut.acc_q[0]), 32'h0);

    // Reset right after an accepted ACC discards it; in_valid during reset is ignored.
    drive(INI, 32'h0, 32'd5, 32'd5, 1'b1);
    tick();
    idle();
    tick();
    check("pre_rst_acc0", 32'(dut.acc_q[0]), 32'd5);
    drive(ACC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    check("midrst_acc0", 32'(dut.acc_q[0]), 32'h0);
    check("midrst_pool0", 32'(dut.pool_q[0]), 32'h8000);
    check("midrst_activ", 32'(activ), 32'h0);
    tick();
    tick();
    check("postrst_acc0", 32'(dut.acc_q[0]), 32'h0);
    check("postrst_acc1", 32'(dut.acc_q[1]), 32'h0);

    // Overflow behaviour of ACC and NORM.
    drive(INI, 32'h0, 32'h00007FF0, 32'h0, 1'b1);
    tick();
    drive(ACC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
    tick();
    drive(POOL, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    check("ovf_acc0", 32'(dut.acc_q[0]),
`ifdef SATURATE_EN
          32'h7FFF);
`else
          32'h8030);
`endif
    drive(NORM, 32'h0, 32'h0, 32'h0, 1'b1);
    tick();
    idle();
    tick();
    check("ovf_norm_pool0", 32'(dut.pool_q[0]),
`ifdef SATURATE_EN
          32'h7FFF);
`else
          32'h0C00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
